mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB stage: registers ALU results and data-memory load returns, then drives the register-file write port (dst_addr, dst_data, we, irq_ctrl_wb).
//  Drives mem_wb_freeze to the register file and to the upstream pipeline while a load waits on dmem_ready.
//  Aligns and extends load data (byte, half or word, signed or unsigned).
// PARAMETERS
//  TIMEOUT  255  Max LOAD_WAIT cycles before abort, range 1..255. Used only with DMEM_TIMEOUT_EN.
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  rst            in   1   asynchronous, active-low reset (rst==0 resets immediately)
//  in_valid       in   1   upstream instruction valid
//  in_rd          in   5   destination register
//  in_we          in   1   instruction writes rd
//  in_result      in   32  ALU/CSR result (non-load)
//  in_is_load     in   1   instruction is a load
//  in_ld_size     in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  in_ld_unsigned in   1   zero-extend (1) / sign-extend (0)
//  in_addr_lo     in   2   load address bits [1:0]
//  in_irq_ctrl    in   1   write targets shadow bank
//  dmem_rdata     in   32  data-memory read word, little-endian
//  dmem_ready     in   1   load data valid this cycle
//  dst_addr       out  5   RF write address
//  dst_data       out  32  RF write data
//  we             out  1   RF write enable, 1-cycle pulse per write
//  irq_ctrl_wb    out  1   RF shadow-bank select, valid with we
//  mem_wb_freeze  out  1   stall upstream and RF
//  misalign_err   out  1   1-cycle pulse: misaligned load dropped
//  timeout_err    out  1   1-cycle pulse: load aborted, tied 0 without macro
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal registers 0; any pending load is discarded.
//  Freeze: mem_wb_freeze = (state==LOAD_WAIT), combinational. While it is 1, in_* are ignored and upstream holds.
//  Accept: in_valid & ~mem_wb_freeze.
//  FSM IDLE:
//   - Accept non-load: next edge loads dst_addr=in_rd, dst_data=in_result, irq_ctrl_wb=in_irq_ctrl, we=in_we & |in_rd. Latency 1.
//   - Accept load: latch rd, size, unsigned, addr_lo, irq_ctrl; next edge sets we=0 and state=LOAD_WAIT.
//   - Misaligned load (half with addr_lo==3, or word/reserved with addr_lo!=0): no state change; next edge sets we=0 and misalign_err=1.
//   - No accept: we=0 next edge; dst_addr and dst_data hold.
//  FSM LOAD_WAIT:
//   - dmem_ready is sampled only here; in IDLE it is ignored.
//   - dmem_ready=1: next edge sets dst_data=aligned data, dst_addr=latched rd, we=|rd, state=IDLE.
//   - Load latency: accept at cycle 0, ready at cycle k (k>=1), we at cycle k+1. The next instruction is accepted at cycle k+1.
//  Align:
//   - byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16]; word = rdata.
//   - Extend to 32 bits: zeros if unsigned, else the MSB of the selected field.
//  Writes to rd=0 are never issued (we=0), but the stage still sequences normally.
//  we is never high while mem_wb_freeze is high.
//  Async reset during LOAD_WAIT: return to IDLE; a later dmem_ready produces no write.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//   - An 8-bit counter clears on entry to LOAD_WAIT and increments each LOAD_WAIT cycle with dmem_ready=0.
//   - When the count reaches TIMEOUT with no ready: next edge sets state=IDLE, we=0, timeout_err=1 for one cycle.
//   - dmem_ready in the same cycle as expiry wins: a normal write, no error.
//  DMEM_TIMEOUT_EN undefined: no counter; LOAD_WAIT waits indefinitely; timeout_err=0 constantly.
// TESTING
//  1 ALU: accept rd=5, result=0x1234, in_we=1 -> next cycle we=1, dst_addr=5, dst_data=0x1234; then we=0.
//  2 lb signed, addr_lo=2, rdata=0x00800000, ready 3 cycles after accept -> freeze high 3 cycles, then dst_data=0xFFFFFF80, we=1; lbu gives 0x00000080.
//  3 lh addr_lo=3 -> misalign_err pulse, we=0, freeze stays 0; lw addr_lo=0, rdata=0xDEADBEEF -> dst_data=0xDEADBEEF.
//  4 rd=0 ALU and rd=0 load -> we never asserts; load still freezes until ready; irq_ctrl=1 write to rd=3 -> irq_ctrl_wb=1 with we.
//  5 rst low mid-LOAD_WAIT, then ready -> outputs 0, no write, freeze 0; back-to-back ALU, ALU, load, ALU -> we pattern 1,1,0,…,1,1.
//  6 DMEM_TIMEOUT_EN, TIMEOUT=4, no ready -> timeout_err pulse after 4 wait cycles, state IDLE; ready on 4th cycle -> normal write, no error.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: registers ALU results and load returns, drives the register-file write port.
// Optional load timeout is built in when DMEM_TIMEOUT_EN is defined.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [1:0]  in_ld_size,
  input  logic        in_ld_unsigned,
  input  logic [1:0]  in_addr_lo,
  input  logic        in_irq_ctrl,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [4:0]  dst_addr,
  output logic [31:0] dst_data,
  output logic        we,
  output logic        irq_ctrl_wb,
  output logic        mem_wb_freeze,
  output logic        misalign_err,
  output logic        timeout_err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_wb_stage: TIMEOUT must be in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e      state_q, state_d;
  logic [4:0]  dst_addr_q, dst_addr_d;
  logic [31:0] dst_data_q, dst_data_d;
  logic        we_q, we_d;
  logic        irq_q, irq_d;
  logic        mis_q, mis_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        ld_irq_q, ld_irq_d;
  logic        tmo_d;
  logic        accept, misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  assign mem_wb_freeze = (state_q == StLoadWait);
  assign accept        = in_valid & ~mem_wb_freeze;
  // Halfwords only straddle the word at offset 3; words must be word aligned.
  assign misaligned    = ((in_ld_size == 2'b01) && (in_addr_lo == 2'b11)) ||
                         (in_ld_size[1] && (in_addr_lo != 2'b00));

  always_comb begin
    byte_sel = 8'h00;
    unique case (ld_lo_q)
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = ld_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (ld_size_q == 2'b00) begin
      ld_data = {{24{~ld_uns_q & byte_sel[7]}}, byte_sel};
    end else if (ld_size_q == 2'b01) begin
      ld_data = {{16{~ld_uns_q & half_sel[15]}}, half_sel};
    end else begin
      ld_data = dmem_rdata;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q;
  logic       expire;
  assign expire      = ~dmem_ready && (cnt_q == 8'(TIMEOUT - 1));
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    we_d       = 1'b0;
    irq_d      = irq_q;
    mis_d      = 1'b0;
    tmo_d      = 1'b0;
    ld_rd_d    = ld_rd_q;
    ld_size_d  = ld_size_q;
    ld_uns_d   = ld_uns_q;
    ld_lo_d    = ld_lo_q;
    ld_irq_d   = ld_irq_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!in_is_load) begin
            dst_addr_d = in_rd;
            dst_data_d = in_result;
            irq_d      = in_irq_ctrl;
            we_d       = in_we & (|in_rd);
          end else if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            ld_rd_d   = in_rd;
            ld_size_d = in_ld_size;
            ld_uns_d  = in_ld_unsigned;
            ld_lo_d   = in_addr_lo;
            ld_irq_d  = in_irq_ctrl;
            state_d   = StLoadWait;
`ifdef DMEM_TIMEOUT_EN
            cnt_d     = 8'd0;
`endif
          end
        end
      end
      StLoadWait: begin
        if (dmem_ready) begin
          dst_addr_d = ld_rd_q;
          dst_data_d = ld_data;
          irq_d      = ld_irq_q;
          we_d       = |ld_rd_q;
          state_d    = StIdle;
`ifdef DMEM_TIMEOUT_EN
        end else if (expire) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      dst_addr_q <= 5'd0;
      dst_data_q <= 32'd0;
      we_q       <= 1'b0;
      irq_q      <= 1'b0;
      mis_q      <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_size_q  <= 2'd0;
      ld_uns_q   <= 1'b0;
      ld_lo_q    <= 2'd0;
      ld_irq_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q      <= 8'd0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      we_q       <= we_d;
      irq_q      <= irq_d;
      mis_q      <= mis_d;
      ld_rd_q    <= ld_rd_d;
      ld_size_q  <= ld_size_d;
      ld_uns_q   <= ld_uns_d;
      ld_lo_q    <= ld_lo_d;
      ld_irq_q   <= ld_irq_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

`ifndef DMEM_TIMEOUT_EN
  logic unused_tmo;
  assign unused_tmo = tmo_d;
`endif

  assign dst_addr     = dst_addr_q;
  assign dst_data     = dst_data_q;
  assign we           = we_q;
  assign irq_ctrl_wb  = irq_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; define DMEM_TIMEOUT_EN to cover the abort path.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_we = 1'b0;
  logic [31:0] in_result = 32'd0;
  logic        in_is_load = 1'b0;
  logic [1:0]  in_ld_size = 2'd0;
  logic        in_ld_unsigned = 1'b0;
  logic [1:0]  in_addr_lo = 2'd0;
  logic        in_irq_ctrl = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ready = 1'b0;
  logic [4:0]  dst_addr;
  logic [31:0] dst_data;
  logic        we, irq_ctrl_wb, mem_wb_freeze, misalign_err, timeout_err;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rd(in_rd), .in_we(in_we),
    .in_result(in_result), .in_is_load(in_is_load), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo), .in_irq_ctrl(in_irq_ctrl),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .dst_addr(dst_addr),
    .dst_data(dst_data), .we(we), .irq_ctrl_wb(irq_ctrl_wb),
    .mem_wb_freeze(mem_wb_freeze), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res, input logic w);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_result = res; in_we = w;
  endtask

  task automatic load(input logic [4:0] rd, input logic [1:0] sz, input logic uns,
                      input logic [1:0] lo);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_we = 1'b1;
    in_ld_size = sz; in_ld_unsigned = uns; in_addr_lo = lo;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_is_load = 1'b0; in_irq_ctrl = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if ({dst_addr, dst_data, we, irq_ctrl_wb, mem_wb_freeze, misalign_err, timeout_err} !== 43'd0)
      begin n_fail++; $display("FAIL reset_outputs: got addr=%0d data=%h we=%b frz=%b", dst_addr,
      dst_data, we, mem_wb_freeze); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    alu(5'd5, 32'h1234, 1'b1);
    step();
    idle_in();
    n_checks++;
    if ({we, dst_addr, dst_data} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++;
      $display("FAIL alu_write: got we=%b addr=%0d data=%h want 1/5/00001234", we, dst_addr,
      dst_data); end
    step();
    n_checks++;
    if ({we, dst_data} !== {1'b0, 32'h1234}) begin n_fail++;
      $display("FAIL alu_hold: got we=%b data=%h want 0/00001234", we, dst_data); end
  endtask

  task automatic test_load_byte();
    load(5'd7, 2'b00, 1'b0, 2'd2);
    step();
    idle_in();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin dmem_ready = 1'b1; dmem_rdata = 32'h0080_0000; end
      n_checks++;
      if ({mem_wb_freeze, we} !== 2'b10) begin n_fail++;
        $display("FAIL lb_wait_c%0d: got frz=%b we=%b want 1/0", c, mem_wb_freeze, we); end
      step();
    end
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, mem_wb_freeze, dst_addr, dst_data} !== {2'b10, 5'd7, 32'hFFFF_FF80}) begin n_fail++;
      $display("FAIL lb_signed: got we=%b frz=%b addr=%0d data=%h want 1/0/7/ffffff80", we,
      mem_wb_freeze, dst_addr, dst_data); end
    load(5'd8, 2'b00, 1'b1, 2'd2);
    step();
    idle_in();
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, dst_addr, dst_data} !== {1'b1, 5'd8, 32'h0000_0080}) begin n_fail++;
      $display("FAIL lbu: got we=%b addr=%0d data=%h want 1/8/00000080", we, dst_addr, dst_data); end
  endtask

  task automatic test_misalign_and_word();
    load(5'd9, 2'b01, 1'b0, 2'd3);
    step();
    idle_in();
    n_checks++;
    if ({misalign_err, we, mem_wb_freeze, dst_addr} !== {3'b100, 5'd8}) begin n_fail++;
      $display("FAIL lh_misalign: got err=%b we=%b frz=%b addr=%0d want 1/0/0/8", misalign_err,
      we, mem_wb_freeze, dst_addr); end
    step();
    n_checks++;
    if (misalign_err !== 1'b0) begin n_fail++;
      $display("FAIL misalign_pulse: got err=%b want 0", misalign_err); end
    load(5'd9, 2'b10, 1'b0, 2'd1);
    step();
    idle_in();
    n_checks++;
    if ({misalign_err, mem_wb_freeze} !== 2'b10) begin n_fail++;
      $display("FAIL lw_misalign: got err=%b frz=%b want 1/0", misalign_err, mem_wb_freeze); end
    load(5'd10, 2'b10, 1'b0, 2'd0);
    step();
    idle_in();
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, dst_addr, dst_data} !== {1'b1, 5'd10, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL lw: got we=%b addr=%0d data=%h want 1/10/deadbeef", we, dst_addr, dst_data); end
    load(5'd11, 2'b01, 1'b0, 2'd2);
    step();
    idle_in();
    dmem_ready = 1'b1; dmem_rdata = 32'h8001_1234;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, dst_data} !== {1'b1, 32'hFFFF_8001}) begin n_fail++;
      $display("FAIL lh_upper: got we=%b data=%h want 1/ffff8001", we, dst_data); end
  endtask

  task automatic test_rd0_and_irq();
    alu(5'd0, 32'h55, 1'b1);
    step();
    idle_in();
    n_checks++;
    if (we !== 1'b0) begin n_fail++; $display("FAIL rd0_alu: got we=%b want 0", we); end
    load(5'd0, 2'b10, 1'b0, 2'd0);
    step();
    idle_in();
    n_checks++;
    if ({mem_wb_freeze, we} !== 2'b10) begin n_fail++;
      $display("FAIL rd0_load_freeze: got frz=%b we=%b want 1/0", mem_wb_freeze, we); end
    dmem_ready = 1'b1; dmem_rdata = 32'h1;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({mem_wb_freeze, we} !== 2'b00) begin n_fail++;
      $display("FAIL rd0_load_done: got frz=%b we=%b want 0/0", mem_wb_freeze, we); end
    alu(5'd3, 32'hABCD, 1'b1);
    in_irq_ctrl = 1'b1;
    step();
    idle_in();
    n_checks++;
    if ({we, irq_ctrl_wb, dst_addr} !== {2'b11, 5'd3}) begin n_fail++;
      $display("FAIL irq_write: got we=%b irq=%b addr=%0d want 1/1/3", we, irq_ctrl_wb, dst_addr); end
  endtask

  task automatic test_reset_mid_load();
    load(5'd12, 2'b10, 1'b0, 2'd0);
    step();
    idle_in();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_wb_freeze, we, dst_addr, dst_data, irq_ctrl_wb} !== 40'd0) begin n_fail++;
      $display("FAIL async_reset: got frz=%b we=%b addr=%0d data=%h", mem_wb_freeze, we, dst_addr,
      dst_data); end
    #3 rst = 1'b1;
    step();
    dmem_ready = 1'b1; dmem_rdata = 32'h77;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, mem_wb_freeze, dst_data} !== 34'd0) begin n_fail++;
      $display("FAIL ready_after_reset: got we=%b frz=%b data=%h want 0/0/0", we, mem_wb_freeze,
      dst_data); end
  endtask

  task automatic test_back_to_back();
    alu(5'd1, 32'h11, 1'b1);
    step();
    n_checks++;
    if ({we, dst_addr} !== {1'b1, 5'd1}) begin n_fail++;
      $display("FAIL b2b_alu1: got we=%b addr=%0d want 1/1", we, dst_addr); end
    alu(5'd2, 32'h22, 1'b1);
    step();
    n_checks++;
    if ({we, dst_addr} !== {1'b1, 5'd2}) begin n_fail++;
      $display("FAIL b2b_alu2: got we=%b addr=%0d want 1/2", we, dst_addr); end
    load(5'd3, 2'b10, 1'b0, 2'd0);
    step();
    n_checks++;
    if ({we, mem_wb_freeze} !== 2'b01) begin n_fail++;
      $display("FAIL b2b_load: got we=%b frz=%b want 0/1", we, mem_wb_freeze); end
    alu(5'd4, 32'h44, 1'b1);
    dmem_ready = 1'b1; dmem_rdata = 32'h33;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, dst_addr, dst_data} !== {1'b1, 5'd3, 32'h33}) begin n_fail++;
      $display("FAIL b2b_ldwr: got we=%b addr=%0d data=%h want 1/3/33", we, dst_addr, dst_data); end
    step();
    idle_in();
    n_checks++;
    if ({we, dst_addr, dst_data} !== {1'b1, 5'd4, 32'h44}) begin n_fail++;
      $display("FAIL b2b_alu4: got we=%b addr=%0d data=%h want 1/4/44", we, dst_addr, dst_data); end
    step();
    n_checks++;
    if (we !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got we=%b want 0", we); end
  endtask

  task automatic test_timeout();
`ifdef DMEM_TIMEOUT_EN
    load(5'd13, 2'b10, 1'b0, 2'd0);
    step();
    idle_in();
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if ({mem_wb_freeze, timeout_err} !== 2'b10) begin n_fail++;
        $display("FAIL tmo_wait_c%0d: got frz=%b err=%b want 1/0", c, mem_wb_freeze, timeout_err); end
      step();
    end
    n_checks++;
    if ({timeout_err, mem_wb_freeze, we} !== 3'b100) begin n_fail++;
      $display("FAIL tmo_abort: got err=%b frz=%b we=%b want 1/0/0", timeout_err, mem_wb_freeze, we); end
    step();
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got err=%b want 0", timeout_err); end
    load(5'd14, 2'b10, 1'b0, 2'd0);
    step();
    idle_in();
    step(); step(); step();
    dmem_ready = 1'b1; dmem_rdata = 32'h99;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, timeout_err, dst_addr, dst_data} !== {2'b10, 5'd14, 32'h99}) begin n_fail++;
      $display("FAIL tmo_ready_wins: got we=%b err=%b addr=%0d data=%h want 1/0/14/99", we,
      timeout_err, dst_addr, dst_data); end
`else
    load(5'd13, 2'b10, 1'b0, 2'd0);
    step();
    idle_in();
    repeat (20) step();
    n_checks++;
    if ({mem_wb_freeze, timeout_err} !== 2'b10) begin n_fail++;
      $display("FAIL no_timeout: got frz=%b err=%b want 1/0", mem_wb_freeze, timeout_err); end
    dmem_ready = 1'b1; dmem_rdata = 32'h99;
    step();
    dmem_ready = 1'b0;
    n_checks++;
    if ({we, dst_addr, dst_data} !== {1'b1, 5'd13, 32'h99}) begin n_fail++;
      $display("FAIL late_ready: got we=%b addr=%0d data=%h want 1/13/99", we, dst_addr, dst_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_misalign_and_word();
    test_rd0_and_irq();
    test_reset_mid_load();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
